// File: rtl/uart_hex_rx.sv
// uart_hex_rx: 8N1 UART receiver with an ASCII-hex decoder.
// Recovers bytes from the serial line, publishes each well-framed byte and,
// when the byte is an ASCII hex digit (0-9, A-F, a-f), the matching nibble.
// A bad stop bit reports a framing error and parks the receiver in BREAK
// until the line returns high, so a held-low line is never read as a
// stream of start bits.
module uart_hex_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic [3:0] hex,
    output logic       hex_valid,
    output logic       frame_err,
    output logic       busy
);

    // Bit-timing counter width; it only ever counts up to CLKS_PER_BIT-1.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Terminal counts: mid-start-bit, and one full bit period.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             rx_meta_r;
    logic             rxs_r;
    logic [4:0]       decode_s;

    // ASCII hex digit to nibble. Bit 4 flags a valid digit; bits 3:0 hold
    // the value. Letters use the low nibble of the code plus 9, which works
    // for both 'A'-'F' (0x41-0x46) and 'a'-'f' (0x61-0x66).
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        logic [4:0] r;
        r = 5'h00;
        if ((b >= 8'h30) && (b <= 8'h39)) begin
            r = {1'b1, b[3:0]};
        end else if (((b >= 8'h41) && (b <= 8'h46)) ||
                     ((b >= 8'h61) && (b <= 8'h66))) begin
            r = {1'b1, b[3:0] + 4'h9};
        end else begin
            r = 5'h00;
        end
        return r;
    endfunction

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rxs_r     <= rx_meta_r;
        end
    end

    // Decode of the fully assembled byte, consumed at the stop-bit sample.
    always_comb begin
        decode_s = 5'h00;
        decode_s = hex_decode(shift_r);
    end

    // Receiver FSM with counters, shift register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            data       <= 8'h00;
            hex        <= 4'h0;
            data_valid <= 1'b0;
            hex_valid  <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Status pulses last one cycle unless re-asserted below.
            data_valid <= 1'b0;
            hex_valid  <= 1'b0;
            frame_err  <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    cnt_r     <= CNT_ZERO;
                    bit_idx_r <= 3'd0;
                    if (!rxs_r) begin
                        state_r <= ST_START;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end

                ST_START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r <= CNT_ZERO;
                        if (!rxs_r) begin
                            // Still low at mid-bit: a genuine start bit.
                            state_r   <= ST_DATA;
                            bit_idx_r <= 3'd0;
                        end else begin
                            // Line recovered before mid-bit: a glitch.
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_DATA: begin
                    if (cnt_r == FULL_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        shift_r <= {rxs_r, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_STOP: begin
                    if (cnt_r == FULL_LAST) begin
                        cnt_r <= CNT_ZERO;
                        if (rxs_r) begin
                            data       <= shift_r;
                            data_valid <= 1'b1;
                            if (decode_s[4]) begin
                                hex       <= decode_s[3:0];
                                hex_valid <= 1'b1;
                            end else begin
                                hex_valid <= 1'b0;
                            end
                            // Back to IDLE at mid-stop so a back-to-back
                            // start bit is caught on its falling edge.
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state_r   <= ST_BREAK;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_BREAK: begin
                    cnt_r <= CNT_ZERO;
                    if (rxs_r) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        state_r <= ST_BREAK;
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= CNT_ZERO;
                    bit_idx_r <= 3'd0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_rx.sv
// Self-checking bench for uart_hex_rx at the default 115200-baud timing.
// The stimulus records, for every frame it sends, when the outcome must
// appear and what it must be; a compare process checks every cycle.
module tb_uart_hex_rx;

    localparam int CPB     = 434;
    localparam int LATENCY = 4125;  // first low edge -> data_valid
    localparam int TOL     = 2;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic [3:0] hex;
    logic       hex_valid;
    logic       frame_err;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int         when;
        bit         is_err;
        logic [7:0] b;
    } ev_t;

    ev_t        exp_q[$];
    int         dv_times[$];
    ev_t        cur_e;
    logic [4:0] cur_dec;
    logic [7:0] m_data = 8'h00;
    logic [3:0] m_hex  = 4'h0;
    bit         glitch_mon = 1'b0;
    int         bcount = 0;

    uart_hex_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .hex        (hex),
        .hex_valid  (hex_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference meaning of an ASCII hex character: {is_digit, value}.
    function automatic logic [4:0] model_hex(input logic [7:0] b);
        int v;
        v = int'(b);
        if (v >= 48 && v <= 57)  return {1'b1, 4'(v - 48)};
        if (v >= 65 && v <= 70)  return {1'b1, 4'(v - 55)};
        if (v >= 97 && v <= 102) return {1'b1, 4'(v - 87)};
        return 5'h00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Advance n clock edges, ending just after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame with the given stop bit and bit period; called
    // just after a rising edge and returns in the same phase.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int period, input bit expect_ev);
        logic [9:0] bits;
        ev_t        ev;
        bits = {stop_bit, b, 1'b0};
        if (expect_ev) begin
            ev.when   = cyc + 1 + LATENCY;
            ev.is_err = !stop_bit;
            ev.b      = b;
            exp_q.push_back(ev);
        end
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            idle(period);
        end
    endtask

    // Busy-length monitor for the glitch case.
    always @(negedge clk) begin
        if (glitch_mon && busy) bcount <= bcount + 1;
    end

    // Compare DUT outputs against the model on every cycle.
    always @(negedge clk) begin
        if (rst) begin
            m_data = 8'h00;
            m_hex  = 4'h0;
            exp_q.delete();
            check("reset_outputs", {18'h0, data, hex, data_valid, hex_valid, frame_err, busy}, 32'h0);
        end else if (data_valid || frame_err || hex_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: dv=%0b hv=%0b fe=%0b at cycle %0d, required no pulse",
                         data_valid, hex_valid, frame_err, cyc);
            end else begin
                cur_e = exp_q.pop_front();
                check_range("pulse_time", cyc, cur_e.when - TOL, cur_e.when + TOL);
                if (cur_e.is_err) begin
                    check("fe_pulse", {29'h0, frame_err, data_valid, hex_valid}, 32'h4);
                    check("fe_data_held", data, m_data);
                    check("fe_hex_held", hex, m_hex);
                end else begin
                    cur_dec = model_hex(cur_e.b);
                    check("dv_fe", {30'h0, data_valid, frame_err}, 32'h2);
                    check("rx_data", data, cur_e.b);
                    check("hex_valid", hex_valid, cur_dec[4]);
                    check("rx_hex", hex, cur_dec[4] ? cur_dec[3:0] : m_hex);
                    m_data = cur_e.b;
                    if (cur_dec[4]) m_hex = cur_dec[3:0];
                    dv_times.push_back(cyc);
                end
            end
        end else begin
            if (exp_q.size() > 0 && cyc > exp_q[0].when + TOL) begin
                tests++;
                fails++;
                $display("FAIL missed_pulse: nothing by cycle %0d, required pulse at %0d",
                         cyc, exp_q[0].when);
                void'(exp_q.pop_front());
            end
            check("data_hold", data, m_data);
            check("hex_hold", hex, m_hex);
        end
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        idle(5);
        check("por_data", data, 8'h00);
        check("por_busy", busy, 1'b0);
        rst = 1'b0;
        idle(20);

        // 'A' -> hex A.
        send_frame(8'h41, 1'b1, CPB, 1'b1);
        idle(50);
        check("A_data", data, 8'h41);
        check("A_hex", hex, 4'hA);

        // 'z' -> data only, hex keeps A.
        send_frame(8'h7A, 1'b1, CPB, 1'b1);
        idle(50);
        check("z_data", data, 8'h7A);
        check("z_hex", hex, 4'hA);
        check("z_dv_count", dv_times.size(), 2);

        // Reset in idle clears outputs without a clock edge.
        rst = 1'b1;
        #1;
        check("async_rst_data", data, 8'h00);
        check("async_rst_hex", hex, 4'h0);
        idle(3);
        rst = 1'b0;
        idle(10);

        // 100-cycle low glitch: no pulse, short busy.
        bcount     = 0;
        glitch_mon = 1'b1;
        rx = 1'b0;
        idle(100);
        rx = 1'b1;
        idle(300);
        glitch_mon = 1'b0;
        check_range("glitch_busy_len", bcount, 1, 219);
        check("glitch_idle", busy, 1'b0);

        // Bad stop bit, then line held low for 3 bit periods.
        send_frame(8'h55, 1'b0, CPB, 1'b1);
        idle(3 * CPB);
        check("break_busy", busy, 1'b1);
        rx = 1'b1;
        idle(5);
        check("break_exit", busy, 1'b0);
        check("break_data_held", data, 8'h00);
        idle(20);

        // '3' and 'f' back to back.
        send_frame(8'h33, 1'b1, CPB, 1'b1);
        idle(0);
        check("three_hex", hex, 4'h3);
        send_frame(8'h66, 1'b1, CPB, 1'b1);
        idle(50);
        check("f_hex", hex, 4'hF);
        check("b2b_dv_count", dv_times.size(), 4);
        if (dv_times.size() >= 4)
            check_range("b2b_spacing", dv_times[3] - dv_times[2], 4340 - TOL, 4340 + TOL);

        // Reset during data bits: partial byte dropped.
        rx = 1'b0; idle(CPB);
        rx = 1'b1; idle(CPB);
        rx = 1'b0; idle(CPB);
        rx = 1'b1; idle(200);
        check("midbyte_busy", busy, 1'b1);
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        check("midbyte_rst_busy", busy, 1'b0);
        check("midbyte_rst_data", data, 8'h00);
        idle(3);
        rst = 1'b0;
        idle(20);
        send_frame(8'h37, 1'b1, CPB, 1'b1);
        idle(50);
        check("seven_data", data, 8'h37);
        check("seven_hex", hex, 4'h7);

        // +/-2% baud mismatch.
        send_frame(8'h63, 1'b1, 443, 1'b1);
        idle(50);
        check("slow_c_hex", hex, 4'hC);
        send_frame(8'h42, 1'b1, 425, 1'b1);
        idle(50);
        check("fast_B_data", data, 8'h42);
        check("fast_B_hex", hex, 4'hB);

        idle(20);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
